// File: rtl/dvp_tx.sv
// DVP camera-style transmitter: RGB565 pixels out as two bytes per pixel
// with VSYNC/HREF framing over whole-line vertical states.
`timescale 1ns/1ps
module dvp_tx #(
  parameter int H_RES     = 800,
  parameter int H_BLANK   = 160,
  parameter int V_RES     = 600,
  parameter int VS_LINES  = 3,
  parameter int VBP_LINES = 17,
  parameter int VFP_LINES = 10
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_en,
  input  logic        I_pix_valid,
  input  logic [15:0] I_pix_data,
  output logic        O_pix_ready,
  output logic        O_vsync,
  output logic        O_href,
  output logic [9:0]  O_pixdata,
  output logic        O_underrun,
  output logic        O_frame_done,
  output logic [15:0] O_frame_cnt
);

  localparam logic [12:0] LINE_M1 = 13'(2*H_RES + H_BLANK - 1);
  localparam logic [12:0] ACT_W   = 13'(2*H_RES);
  localparam logic [11:0] VS_M1   = 12'(VS_LINES - 1);
  localparam logic [11:0] VBP_M1  = 12'((VBP_LINES > 0) ? VBP_LINES - 1 : 0);
  localparam logic [11:0] VACT_M1 = 12'(V_RES - 1);
  localparam logic [11:0] VFP_M1  = 12'((VFP_LINES > 0) ? VFP_LINES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBP,
    S_ACTIVE,
    S_VFP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [12:0] r_h;
  logic [12:0] w_h_nxt;
  logic [11:0] r_v;
  logic [11:0] w_v_nxt;
  logic [11:0] w_len_m1;
  logic        w_line_end;
  logic        w_last_line;
  logic        w_eof;
  logic        w_slot_act;
  logic        w_ready;

  logic        r_vsync;
  logic        r_href;
  logic [9:0]  r_pixdata;
  logic [7:0]  r_lo;
  logic        r_underrun;
  logic        r_frame_done;
  logic [15:0] r_frame_cnt;

  always_comb begin
    w_len_m1 = 12'd0;
    unique case (r_state)
      S_VSYNC:  w_len_m1 = VS_M1;
      S_VBP:    w_len_m1 = VBP_M1;
      S_ACTIVE: w_len_m1 = VACT_M1;
      S_VFP:    w_len_m1 = VFP_M1;
      default:  w_len_m1 = 12'd0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = r_h;
    w_v_nxt     = r_v;
    w_eof       = 1'b0;
    w_line_end  = (r_h == LINE_M1);
    w_last_line = (r_v == w_len_m1);
    if (r_state == S_IDLE) begin
      w_h_nxt = 13'd0;
      w_v_nxt = 12'd0;
      if (I_en) w_state_nxt = S_VSYNC;
    end else begin
      w_h_nxt = w_line_end ? 13'd0 : r_h + 13'd1;
      if (w_line_end) begin
        w_v_nxt = w_last_line ? 12'd0 : r_v + 12'd1;
        if (w_last_line) begin
          unique case (r_state)
            S_VSYNC:
              w_state_nxt = (VBP_LINES == 0) ? S_ACTIVE : S_VBP;
            S_VBP:
              w_state_nxt = S_ACTIVE;
            S_ACTIVE:
              if (VFP_LINES == 0) w_eof = 1'b1;
              else w_state_nxt = S_VFP;
            S_VFP:
              w_eof = 1'b1;
            default: ;
          endcase
          // a frame always runs to completion; I_en is sampled only here
          if (w_eof) w_state_nxt = I_en ? S_VSYNC : S_IDLE;
        end
      end
    end
  end

  always_comb begin
    w_slot_act = (w_state_nxt == S_ACTIVE) && (w_h_nxt < ACT_W);
    w_ready    = w_slot_act && !w_h_nxt[0];
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state <= S_IDLE;
      r_h     <= 13'd0;
      r_v     <= 12'd0;
    end else begin
      r_state <= w_state_nxt;
      r_h     <= w_h_nxt;
      r_v     <= w_v_nxt;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_pixdata    <= 10'd0;
      r_lo         <= 8'd0;
      r_underrun   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_vsync      <= (w_state_nxt == S_VSYNC);
      r_href       <= w_slot_act;
      r_underrun   <= w_ready && !I_pix_valid;
      r_frame_done <= w_eof;
      if (w_ready) begin
        // a missing pixel becomes a black pixel so line timing never slips
        r_pixdata <= I_pix_valid ? {I_pix_data[15:8], 2'b00} : 10'd0;
        r_lo      <= I_pix_valid ? I_pix_data[7:0] : 8'd0;
      end else if (w_slot_act) begin
        r_pixdata <= {r_lo, 2'b00};
      end else begin
        r_pixdata <= 10'd0;
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) r_frame_cnt <= 16'd0;
    else if (w_eof) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  assign O_pix_ready  = w_ready;
  assign O_vsync      = r_vsync;
  assign O_href       = r_href;
  assign O_pixdata    = r_pixdata;
  assign O_underrun   = r_underrun;
  assign O_frame_done = r_frame_done;
  assign O_frame_cnt  = r_frame_cnt;

endmodule

// File: doc/dvp_tx.md
DVP_TX -- requirements
Module: dvp_tx

Interface
REQ-001 The block SHALL have parameter H_RES, default 800, meaning active pixels per line (1..2047).
REQ-002 The block SHALL have parameter H_BLANK, default 160, meaning HREF-low cycles per line (2..4095).
REQ-003 The block SHALL have parameter V_RES, default 600, meaning active lines per frame (1..4095).
REQ-004 The block SHALL have parameter VS_LINES, default 3, meaning lines with O_vsync high (1..4095).
REQ-005 The block SHALL have parameters VBP_LINES, default 17, and VFP_LINES, default 10, meaning back-porch and front-porch lines (0..4095).
REQ-006 The block SHALL have port I_clk, input, 1 bit: the single clock, the DVP byte clock; all outputs launch on its rising edge.
REQ-007 The block SHALL have port I_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 The block SHALL have port I_en, input, 1 bit: stream frames continuously while high.
REQ-009 The block SHALL have port I_pix_valid, input, 1 bit: upstream RGB565 pixel available.
REQ-010 The block SHALL have port I_pix_data, input, 16 bits: RGB565 pixel.
REQ-011 The block SHALL have port O_pix_ready, output, 1 bit: the pixel is consumed at this edge when I_pix_valid is high.
REQ-012 The block SHALL have port O_vsync, output, 1 bit: vertical sync, positive polarity.
REQ-013 The block SHALL have port O_href, output, 1 bit: line-valid, high during active bytes.
REQ-014 The block SHALL have port O_pixdata, output, 10 bits: byte on [9:2], with [1:0] always 0.
REQ-015 The block SHALL have port O_underrun, output, 1 bit: one-cycle pulse when a pixel slot had no valid data.
REQ-016 The block SHALL have port O_frame_done, output, 1 bit: one-cycle pulse at the end of each frame.
REQ-017 The block SHALL have port O_frame_cnt, output, 16 bits: count of completed frames, wrapping.

Function
REQ-018 Line length SHALL be LINE = 2*H_RES + H_BLANK cycles; h_cnt runs 0..LINE-1 and wraps, incrementing the line counter on wrap.
REQ-019 The FSM SHALL have states IDLE, VSYNC, VBP, ACTIVE and VFP; every non-IDLE state lasts whole lines.
REQ-020 In IDLE with I_en=1, the FSM SHALL enter VSYNC next cycle with h_cnt=0; with I_en=0 it SHALL stay in IDLE.
REQ-021 VSYNC SHALL last VS_LINES lines and then go to VBP, or to ACTIVE if VBP_LINES=0.
REQ-022 VBP SHALL last VBP_LINES lines and then go to ACTIVE.
REQ-023 ACTIVE SHALL last V_RES lines and then go to VFP; if VFP_LINES=0, end-of-frame SHALL apply immediately.
REQ-024 At end-of-frame, the block SHALL pulse O_frame_done for 1 cycle and increment O_frame_cnt mod 2^16.
REQ-025 At end-of-frame, the FSM SHALL go to VSYNC if I_en=1, otherwise to IDLE.
REQ-026 I_en deasserted mid-frame SHALL take no effect until end-of-frame; frames are never truncated.
REQ-027 O_vsync SHALL be registered and high exactly during the VSYNC lines.
REQ-028 O_pix_ready SHALL be high only in ACTIVE at the edge that produces byte slot h_cnt with h_cnt < 2*H_RES and h_cnt even.
REQ-029 At each such edge, O_href SHALL register 1 and O_pixdata SHALL register {I_pix_data[15:8],2'b00}, with I_pix_data[7:0] held internally.
REQ-030 At the following edge, O_pixdata SHALL register {held_low_byte,2'b00} with O_href=1, giving 1-cycle latency and 2 cycles per pixel.
REQ-031 If I_pix_valid=0 at a ready edge, both bytes of that pixel SHALL be 0, O_href SHALL remain 1, O_underrun SHALL pulse 1 cycle, and timing SHALL be unaffected.
REQ-032 Outside active byte slots, O_href and O_pixdata SHALL be 0.
REQ-033 Outside ACTIVE, O_pix_ready SHALL be 0 and no pixel SHALL be consumed.
REQ-034 Pixels consumed per frame SHALL be exactly H_RES*V_RES.

Reset
REQ-035 Asserting I_rst_n low SHALL immediately force IDLE, zero all counters, and set all outputs to 0 (O_frame_cnt=0), regardless of state.
REQ-036 A reset mid-line SHALL abandon the frame without pulsing O_frame_done.
REQ-037 After reset release, the block SHALL resume per REQ-020.

Verification (bench params H_RES=4, H_BLANK=4, V_RES=2, VS_LINES=1, VBP_LINES=1, VFP_LINES=1: LINE=12, frame=60 cycles)
REQ-038 The bench SHALL check: I_en=1, always valid, pixels 0xA1B2, 0xC3D4 ... -> O_vsync high 12 cycles; line 3 O_href high 8 cycles; O_pixdata = 0x284, 0x2C8, 0x30C, 0x350 ...
REQ-039 The bench SHALL check: continuous run -> O_frame_done pulses every 60 cycles; O_frame_cnt = 1, 2, 3; exactly 8 ready handshakes per frame.
REQ-040 The bench SHALL check: I_pix_valid=0 on the 3rd ready of a line -> bytes 5 and 6 = 0x000, O_underrun one pulse, O_href still 8 cycles.
REQ-041 The bench SHALL check: I_en dropped at cycle 20 of a frame -> the frame completes (O_frame_done at 60), then IDLE with all outputs 0.
REQ-042 The bench SHALL check: reset asserted during ACTIVE -> outputs 0 immediately, O_frame_cnt=0, no O_frame_done; re-enable -> VSYNC starts 1 cycle later.
REQ-043 The bench SHALL check: O_frame_cnt preloaded by running 65536 frames (or forced) -> wraps from 0xFFFF to 0x0000.
